// File: rtl/tone_sequencer.sv
// Tone sequencer: walks a small table of (phase step, duration, last) entries
// and drives phase_step / wave_en of the wave generator. Each played entry is
// followed by a silent gap; the walk can loop and can be aborted at any time.
module tone_sequencer #(
    parameter int DEPTH     = 16,
    parameter int STEP_W    = 16,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 10
) (
    input  logic                     CLK100MHZ,
    input  logic                     ck_rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [STEP_W-1:0]        cfg_step,
    input  logic [DUR_W-1:0]         cfg_dur,
    input  logic                     cfg_last,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic [STEP_W-1:0]        phase_step,
    output logic                     wave_en,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic                     done
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W   = $clog2(GAP_TICKS + 1);
    localparam int CNT_W   = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t state_r, state_n;

    logic [STEP_W-1:0]  tbl_step_r [DEPTH];
    logic [DUR_W-1:0]   tbl_dur_r  [DEPTH];
    logic               tbl_last_r [DEPTH];

    logic [IDX_W-1:0]   idx_r,   idx_n;
    logic [STEP_W-1:0]  step_r,  step_n;
    logic               wen_r,   wen_n;
    logic               done_r,  done_n;
    logic               busy_r,  busy_n;
    logic [PRESC_W-1:0] presc_r, presc_n;
    logic [CNT_W-1:0]   tick_r,  tick_n;
    logic [CNT_W-1:0]   dur_r,   dur_n;
    logic               last_r,  last_n;

    logic [STEP_W-1:0]  rd_step_s;
    logic [DUR_W-1:0]   rd_dur_s;
    logic               rd_last_s;
    logic               tick_end_s;
    logic               play_end_s;
    logic               gap_end_s;
    logic               wrap_s;
    logic               fin_s;
    logic [PRESC_W-1:0] presc_inc_s;
    logic [CNT_W-1:0]   tick_inc_s;

    // Table write port; contents survive reset and writes are allowed while busy.
    always_ff @(posedge CLK100MHZ) begin
        if (cfg_we) begin
            tbl_step_r[cfg_addr] <= cfg_step;
            tbl_dur_r[cfg_addr]  <= cfg_dur;
            tbl_last_r[cfg_addr] <= cfg_last;
        end
    end

    // The read is sampled at the FETCH edge, so a same-edge write is seen next time.
    assign rd_step_s   = tbl_step_r[idx_r];
    assign rd_dur_s    = tbl_dur_r[idx_r];
    assign rd_last_s   = tbl_last_r[idx_r];

    assign tick_end_s  = (presc_r == PRESC_MAX);
    assign play_end_s  = tick_end_s && (tick_r == (dur_r - CNT_W'(1)));
    assign gap_end_s   = tick_end_s && (tick_r == GAP_LAST);
    assign wrap_s      = (idx_r == IDX_MAX);
    assign fin_s       = ((state_r == ST_FETCH) ? rd_last_s : last_r) || wrap_s;
    assign presc_inc_s = tick_end_s ? '0 : (presc_r + PRESC_W'(1));
    assign tick_inc_s  = tick_end_s ? (tick_r + CNT_W'(1)) : tick_r;

    // State register.
    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; stop overrides everything, including a start.
    always_comb begin
        state_n = state_r;
        if (stop) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_n = ST_FETCH;
                    else       state_n = ST_IDLE;
                end
                ST_FETCH: begin
                    if (rd_dur_s != '0)     state_n = ST_PLAY;
                    else if (fin_s && !loop) state_n = ST_IDLE;
                    else                     state_n = ST_FETCH;
                end
                ST_PLAY: begin
                    if (play_end_s) state_n = ST_GAP;
                    else            state_n = ST_PLAY;
                end
                ST_GAP: begin
                    if (!gap_end_s)          state_n = ST_GAP;
                    else if (fin_s && !loop) state_n = ST_IDLE;
                    else                     state_n = ST_FETCH;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values: index walk, tone outputs, tick counting.
    always_comb begin
        idx_n   = idx_r;
        step_n  = step_r;
        wen_n   = wen_r;
        done_n  = 1'b0;
        presc_n = presc_r;
        tick_n  = tick_r;
        dur_n   = dur_r;
        last_n  = last_r;
        if (stop) begin
            idx_n   = '0;
            step_n  = '0;
            wen_n   = 1'b0;
            presc_n = '0;
            tick_n  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        idx_n   = '0;
                        presc_n = '0;
                        tick_n  = '0;
                    end else begin
                        idx_n   = idx_r;
                    end
                end
                ST_FETCH: begin
                    if (rd_dur_s != '0) begin
                        step_n  = rd_step_s;
                        wen_n   = (rd_step_s != '0);
                        dur_n   = CNT_W'(rd_dur_s);
                        last_n  = rd_last_s;
                        presc_n = '0;
                        tick_n  = '0;
                    end else if (fin_s) begin
                        if (loop) idx_n  = '0;
                        else      done_n = 1'b1;
                    end else begin
                        idx_n = idx_r + IDX_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (play_end_s) begin
                        step_n  = '0;
                        wen_n   = 1'b0;
                        presc_n = '0;
                        tick_n  = '0;
                    end else begin
                        presc_n = presc_inc_s;
                        tick_n  = tick_inc_s;
                    end
                end
                ST_GAP: begin
                    if (!gap_end_s) begin
                        presc_n = presc_inc_s;
                        tick_n  = tick_inc_s;
                    end else if (fin_s) begin
                        presc_n = '0;
                        tick_n  = '0;
                        if (loop) idx_n  = '0;
                        else      done_n = 1'b1;
                    end else begin
                        presc_n = '0;
                        tick_n  = '0;
                        idx_n   = idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    idx_n   = '0;
                    step_n  = '0;
                    wen_n   = 1'b0;
                    presc_n = '0;
                    tick_n  = '0;
                end
            endcase
        end
        busy_n = (state_n != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst) begin
            idx_r   <= '0;
            step_r  <= '0;
            wen_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            presc_r <= '0;
            tick_r  <= '0;
            dur_r   <= '0;
            last_r  <= 1'b0;
        end else begin
            idx_r   <= idx_n;
            step_r  <= step_n;
            wen_r   <= wen_n;
            done_r  <= done_n;
            busy_r  <= busy_n;
            presc_r <= presc_n;
            tick_r  <= tick_n;
            dur_r   <= dur_n;
            last_r  <= last_n;
        end
    end

    assign phase_step = step_r;
    assign wave_en    = wen_r;
    assign busy       = busy_r;
    assign cur_idx    = idx_r;
    assign done       = done_r;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer with TICK_DIV=4, GAP_TICKS=1, DEPTH=4.
// The monitor watches the output tuple {busy, wave_en, phase_step, cur_idx, done}
// and, every time it changes, pops the expected (tuple, run length) from a queue.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        ck_rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_step;
    logic [15:0] cfg_dur;
    logic        cfg_last;
    logic        start;
    logic        stop;
    logic        loop;
    logic [15:0] phase_step;
    logic        wave_en;
    logic        busy;
    logic [1:0]  cur_idx;
    logic        done;

    tone_sequencer #(
        .DEPTH(4), .STEP_W(16), .DUR_W(16), .TICK_DIV(4), .GAP_TICKS(1)
    ) dut (
        .CLK100MHZ(clk), .ck_rst(ck_rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_step(cfg_step), .cfg_dur(cfg_dur), .cfg_last(cfg_last),
        .start(start), .stop(stop), .loop(loop),
        .phase_step(phase_step), .wave_en(wave_en), .busy(busy),
        .cur_idx(cur_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] len;   // 0 = any length
        logic [20:0] tup;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;

    // Push one expected run: outputs held for len cycles (0 = don't care).
    task automatic ex(input logic b, input logic w, input logic [15:0] st,
                      input logic [1:0] ix, input logic d, input int len);
        exp_t e;
        e.len = len;
        e.tup = {b, w, st, ix, d};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] st,
                      input logic [15:0] du, input logic la);
        cfg_addr = a; cfg_step = st; cfg_dur = du; cfg_last = la; cfg_we = 1'b1;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin
            tick(1);
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
        tick(2);
    endtask

    // Monitor: closes a run whenever the output tuple changes and scores it.
    initial begin
        logic [20:0] prev_tup;
        logic [20:0] cur_tup;
        int          run_len;
        bit          started;
        exp_t        e;
        started = 1'b0;
        run_len = 0;
        prev_tup = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur_tup = {busy, wave_en, phase_step, cur_idx, done};
                if (!started) begin
                    prev_tup = cur_tup;
                    run_len  = 1;
                    started  = 1'b1;
                end else if (cur_tup !== prev_tup) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_run: got tuple %h len %0d, expected none",
                                 prev_tup, run_len);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.tup !== prev_tup || (e.len != 0 && e.len != run_len)) begin
                            errors++;
                            $display("FAIL run_check: got tuple %h len %0d, expected tuple %h len %0d",
                                     prev_tup, run_len, e.tup, e.len);
                        end
                    end
                    prev_tup = cur_tup;
                    run_len  = 1;
                end else begin
                    run_len++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ck_rst = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_step = 16'd0;
        cfg_dur = 16'd0; cfg_last = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick(3);
        ck_rst = 1'b1;
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_wen",   {31'd0, wave_en}, 32'd0);
        chk("reset_step",  {16'd0, phase_step}, 32'd0);
        chk("reset_idx",   {30'd0, cur_idx}, 32'd0);
        chk("reset_done",  {31'd0, done}, 32'd0);
        mon_en = 1'b1;
        tick(2);

        // Single tone: 12 play cycles, 4 gap cycles, done pulse.
        wr(2'd0, 16'h0100, 16'd3, 1'b1);
        ex(0,0,16'h0000,0,0,0); ex(1,0,16'h0000,0,0,1); ex(1,1,16'h0100,0,0,12);
        ex(1,0,16'h0000,0,0,4); ex(0,0,16'h0000,0,1,1);
        pulse_start();
        wait_idle("single_idle", 100);

        // Three entries with a rest in the middle; busy totals 35 cycles.
        wr(2'd0, 16'h0010, 16'd2, 1'b0);
        wr(2'd1, 16'h0000, 16'd1, 1'b0);
        wr(2'd2, 16'h0030, 16'd2, 1'b1);
        ex(0,0,16'h0000,0,0,0); ex(1,0,16'h0000,0,0,1); ex(1,1,16'h0010,0,0,8);
        ex(1,0,16'h0000,0,0,4); ex(1,0,16'h0000,1,0,9); ex(1,0,16'h0000,2,0,1);
        ex(1,1,16'h0030,2,0,8); ex(1,0,16'h0000,2,0,4); ex(0,0,16'h0000,2,1,1);
        pulse_start();
        wait_idle("three_idle", 100);

        // Skip (dur 0) and wrap guard at index 3 without any last flag.
        wr(2'd0, 16'h0011, 16'd1, 1'b0);
        wr(2'd1, 16'h0022, 16'd0, 1'b0);
        wr(2'd2, 16'h0033, 16'd1, 1'b0);
        wr(2'd3, 16'h0044, 16'd1, 1'b0);
        ex(0,0,16'h0000,2,0,0); ex(1,0,16'h0000,0,0,1); ex(1,1,16'h0011,0,0,4);
        ex(1,0,16'h0000,0,0,4); ex(1,0,16'h0000,1,0,1); ex(1,0,16'h0000,2,0,1);
        ex(1,1,16'h0033,2,0,4); ex(1,0,16'h0000,2,0,4); ex(1,0,16'h0000,3,0,1);
        ex(1,1,16'h0044,3,0,4); ex(1,0,16'h0000,3,0,4); ex(0,0,16'h0000,3,1,1);
        pulse_start();
        wait_idle("wrap_idle", 100);

        // Loop once, then drop loop during the replay.
        wr(2'd0, 16'h0200, 16'd1, 1'b1);
        loop = 1'b1;
        ex(0,0,16'h0000,3,0,0); ex(1,0,16'h0000,0,0,1); ex(1,1,16'h0200,0,0,4);
        ex(1,0,16'h0000,0,0,5); ex(1,1,16'h0200,0,0,4); ex(1,0,16'h0000,0,0,4);
        ex(0,0,16'h0000,0,1,1);
        pulse_start();
        tick(11);
        loop = 1'b0;
        wait_idle("loop_idle", 100);

        // Stop mid-PLAY: idle next cycle, no done.
        wr(2'd0, 16'h0100, 16'd3, 1'b1);
        ex(0,0,16'h0000,0,0,0); ex(1,0,16'h0000,0,0,1); ex(1,1,16'h0100,0,0,5);
        pulse_start();
        tick(5);
        pulse_stop();
        chk("stop_wen",  {31'd0, wave_en}, 32'd0);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_done", {31'd0, done}, 32'd0);
        tick(2);

        // Start and stop together in IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", {31'd0, busy}, 32'd0);
        tick(2);
        chk("startstop_busy_later", {31'd0, busy}, 32'd0);

        // Start while busy is ignored.
        ex(0,0,16'h0000,0,0,0); ex(1,0,16'h0000,0,0,1); ex(1,1,16'h0100,0,0,12);
        ex(1,0,16'h0000,0,0,4); ex(0,0,16'h0000,0,1,1);
        pulse_start();
        tick(4);
        pulse_start();
        wait_idle("restart_idle", 100);

        // Reset for one cycle mid-GAP, then replay the unchanged table.
        ex(0,0,16'h0000,0,0,0); ex(1,0,16'h0000,0,0,1); ex(1,1,16'h0100,0,0,12);
        ex(1,0,16'h0000,0,0,1); ex(0,0,16'h0000,0,0,0); ex(1,0,16'h0000,0,0,1);
        ex(1,1,16'h0100,0,0,12); ex(1,0,16'h0000,0,0,4); ex(0,0,16'h0000,0,1,1);
        pulse_start();
        tick(13);
        ck_rst = 1'b0;
        tick(1);
        ck_rst = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wen",  {31'd0, wave_en}, 32'd0);
        chk("rst_step", {16'd0, phase_step}, 32'd0);
        chk("rst_idx",  {30'd0, cur_idx}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        tick(3);
        pulse_start();
        wait_idle("rst_replay_idle", 100);

        // Live write of entry 2 while entry 1 plays.
        wr(2'd0, 16'h0010, 16'd2, 1'b0);
        wr(2'd1, 16'h0020, 16'd2, 1'b0);
        wr(2'd2, 16'h0030, 16'd1, 1'b1);
        ex(0,0,16'h0000,0,0,0); ex(1,0,16'h0000,0,0,1); ex(1,1,16'h0010,0,0,8);
        ex(1,0,16'h0000,0,0,4); ex(1,0,16'h0000,1,0,1); ex(1,1,16'h0020,1,0,8);
        ex(1,0,16'h0000,1,0,4); ex(1,0,16'h0000,2,0,1); ex(1,1,16'h0055,2,0,4);
        ex(1,0,16'h0000,2,0,4); ex(0,0,16'h0000,2,1,1);
        pulse_start();
        tick(15);
        wr(2'd2, 16'h0055, 16'd1, 1'b1);
        wait_idle("livewr_idle", 100);

        // All-zero durations with loop: endless FETCH walk, stopped by the bench.
        for (int i = 0; i < 4; i++) wr(i[1:0], 16'h0077, 16'd0, 1'b0);
        loop = 1'b1;
        ex(0,0,16'h0000,2,0,0);
        for (int i = 0; i < 11; i++) ex(1,0,16'h0000,i[1:0],0,1);
        pulse_start();
        tick(10);
        pulse_stop();
        loop = 1'b0;
        chk("zero_loop_busy", {31'd0, busy}, 32'd0);
        tick(3);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
